// File: rtl/lsu_pkg.sv
// Shared load/store size codes, FSM state encoding and the access legality check.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    // A request is issuable only with a legal size code and natural alignment.
    function automatic logic lsu_access_ok(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            LSU_B, LSU_BU: ok = 1'b1;
            LSU_H, LSU_HU: ok = ~off[0];
            LSU_W:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated write data for stores,
// lane extraction with sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wd,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_wd;
        case (st_size)
            LSU_B, LSU_BU: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_wd[7:0]}};
            end
            LSU_H, LSU_HU: begin
                st_be    = 4'b0011 << st_off;
                st_wdata = {2{st_wd[15:0]}};
            end
            LSU_W:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            LSU_B:   ld_data = 32'(ld_byte);
            LSU_BU:  ld_data = {24'd0, ld_byte};
            LSU_H:   ld_data = 32'(ld_half);
            LSU_HU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: stalls the core while a variable-latency memory access
// is outstanding, rejects misaligned/illegal requests and times out dead memory.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e       state, state_nxt;
    logic             we_q;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic             fault_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic        req_ok;
    logic        accept;
    logic        reject;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign req_ok      = lsu_access_ok(core_size_i, core_addr_i[1:0]);
    assign accept      = (state == ST_IDLE) && core_req_i && req_ok;
    assign reject      = (state == ST_IDLE) && core_req_i && !req_ok;
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_BUSY) && !mem_ready_i
                         && (cnt_q == CNT_LAST);

    lsu_align u_align (
        .st_size  (core_size_i),
        .st_off   (core_addr_i[1:0]),
        .st_wd    (core_wd_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_word  (mem_rd_i),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        core_stall_o = 1'b0;
        done_o       = 1'b0;
        misalign_o   = 1'b0;
        err_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    state_nxt = req_ok ? ST_BUSY : ST_FAULT;
                end
            end
            ST_BUSY: begin
                core_stall_o = 1'b1;
                if (mem_ready_i) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_FAULT;
                end
            end
            // The core sees stall drop here and still presents the same
            // instruction, so the request is deliberately not sampled.
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                misalign_o = ~fault_err_q;
                err_o      = fault_err_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            size_q      <= LSU_B;
            off_q       <= 2'b00;
            fault_err_q <= 1'b0;
            cnt_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wd_o    <= 32'd0;
            core_rd_o   <= 32'd0;
        end else begin
            if (accept) begin
                we_q       <= core_we_i;
                size_q     <= core_size_i;
                off_q      <= core_addr_i[1:0];
                cnt_q      <= '0;
                mem_req_o  <= 1'b1;
                mem_we_o   <= core_we_i;
                mem_be_o   <= st_be;
                mem_addr_o <= {core_addr_i[ADDR_W-1:2], 2'b00};
                mem_wd_o   <= st_wdata;
            end
            if (reject) begin
                fault_err_q <= 1'b0;
            end
            if (state == ST_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (mem_ready_i || timeout_hit) begin
                    mem_req_o  <= 1'b0;
                    mem_we_o   <= 1'b0;
                    mem_be_o   <= 4'b0000;
                    mem_addr_o <= '0;
                    mem_wd_o   <= 32'd0;
                end
                if (mem_ready_i && !we_q) begin
                    core_rd_o <= ld_data;
                end
                if (timeout_hit) begin
                    fault_err_q <= 1'b1;
                end
            end
        end
    end

endmodule
